fetch_ctrl_unit: RTL and testbench

Moore-style control sequencer that drives the 16-bit program counter (PC register with write_en/inc/reset controls) and the surrounding fetch datapath: address register, instruction memory read, and instruction register.
It runs the FETCH–DECODE–EXECUTE loop, resolves JMP/JZ/JNZ/HALT, and emits the 3-bit PC control vector directly.
It sits between the divided processor clock domain and the PC/IR/AR registers.

---
 rtl/fetch_ctrl_unit_pkg.sv | 44 ++++
 rtl/fetch_ctrl_unit_if.sv | 31 +++
 rtl/fetch_ctrl_unit_mem_wait_counter.sv | 26 ++
 rtl/fetch_ctrl_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_ctrl_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_unit_pkg.sv
// Shared encodings for the fetch sequencer: state codes, opcodes and PC control bit positions.
// Imported by the sequencer, its wait counter and any block that decodes ctrlsig.
package fetch_ctrl_unit_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PCRST   = 4'd1,
        ST_FETCH_A = 4'd2,
        ST_FETCH_M = 4'd3,
        ST_FETCH_I = 4'd4,
        ST_DECODE  = 4'd5,
        ST_JUMP    = 4'd6,
        ST_EXEC    = 4'd7,
        ST_HALTED  = 4'd8
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JNZ  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int PC_WE  = 0;
    localparam int PC_INC = 1;
    localparam int PC_RST = 2;
    localparam int CTRLW  = 3;

    typedef logic [CTRLW-1:0] pc_ctrl_t;

    function automatic pc_ctrl_t pc_ctrl(input int pos);
        pc_ctrl_t v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // Counter preload so that FETCH_M dwells exactly mem_wait cycles; out-of-range values are clamped.
    function automatic logic [3:0] wait_preload(input int mem_wait);
        if (mem_wait < 1)  return 4'd0;
        if (mem_wait > 15) return 4'd14;
        return 4'(mem_wait - 1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_unit_if.sv
// Control/status bundle between the fetch sequencer (master) and the PC/AR/IR datapath (slave).
// The master samples start/opcode/zflag and drives the strobes, PC control vector and debug state.
interface fetch_ctrl_unit_if #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
);
    import fetch_ctrl_unit_pkg::*;

    logic            start;
    logic [OPW-1:0]  opcode;
    logic            zflag;
    pc_ctrl_t        ctrlsig;
    logic            ar_ld;
    logic            mem_rd;
    logic            ir_ld;
    logic            alu_en;
    logic            halted;
    logic [CNTW-1:0] instr_cnt;
    logic [3:0]      state_o;

    modport master (
        input  start, opcode, zflag,
        output ctrlsig, ar_ld, mem_rd, ir_ld, alu_en, halted, instr_cnt, state_o
    );

    modport slave (
        output start, opcode, zflag,
        input  ctrlsig, ar_ld, mem_rd, ir_ld, alu_en, halted, instr_cnt, state_o
    );

endinterface

// File: rtl/fetch_ctrl_unit_mem_wait_counter.sv
// 4-bit loadable down-counter timing the instruction-memory read dwell; load wins over en.
// Saturates at zero so a stray enable can never wrap it back to 15.
module fetch_ctrl_unit_mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && !zero) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/fetch_ctrl_unit.sv
// Moore sequencer for FETCH-DECODE-EXECUTE: drives PC control, AR/IR loads, memory read and ALU strobe.
// All outputs decode the state register; FETCH_M dwells MEM_WAIT cycles, no other stalls.
module fetch_ctrl_unit
    import fetch_ctrl_unit_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int MEM_WAIT = 2,
    parameter int CNTW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    fetch_ctrl_unit_if.master bus
);

    localparam logic [OPW-1:0] OPC_NOP  = OPW'(OP_NOP);
    localparam logic [OPW-1:0] OPC_JMP  = OPW'(OP_JMP);
    localparam logic [OPW-1:0] OPC_JZ   = OPW'(OP_JZ);
    localparam logic [OPW-1:0] OPC_JNZ  = OPW'(OP_JNZ);
    localparam logic [OPW-1:0] OPC_HALT = OPW'(OP_HALT);
    localparam logic [3:0]     WAIT_PRELOAD = wait_preload(MEM_WAIT);

    state_t          state_q;
    state_t          state_d;
    logic            wait_load;
    logic            wait_en;
    logic            wait_zero;
    logic [CNTW-1:0] cnt_q;

    pc_ctrl_t        ctrl;
    logic            ar_ld;
    logic            mem_rd;
    logic            ir_ld;
    logic            alu_en;
    logic            halted;

    fetch_ctrl_unit_mem_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (wait_load),
        .en       (wait_en),
        .load_val (WAIT_PRELOAD),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = ST_IDLE;
        wait_load = 1'b0;
        wait_en   = 1'b0;
        ctrl      = '0;
        ar_ld     = 1'b0;
        mem_rd    = 1'b0;
        ir_ld     = 1'b0;
        alu_en    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = bus.start ? ST_PCRST : ST_IDLE;
            end
            ST_PCRST: begin
                ctrl    = pc_ctrl(PC_RST);
                state_d = ST_FETCH_A;
            end
            ST_FETCH_A: begin
                ar_ld     = 1'b1;
                wait_load = 1'b1;
                state_d   = ST_FETCH_M;
            end
            ST_FETCH_M: begin
                mem_rd = 1'b1;
                if (wait_zero) begin
                    state_d = ST_FETCH_I;
                end else begin
                    wait_en = 1'b1;
                    state_d = ST_FETCH_M;
                end
            end
            ST_FETCH_I: begin
                // IR load and PC increment share this cycle on purpose.
                ir_ld   = 1'b1;
                ctrl    = pc_ctrl(PC_INC);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (bus.opcode == OPC_NOP) begin
                    state_d = ST_FETCH_A;
                end else if (bus.opcode == OPC_JMP) begin
                    state_d = ST_JUMP;
                end else if (bus.opcode == OPC_JZ) begin
                    state_d = bus.zflag ? ST_JUMP : ST_FETCH_A;
                end else if (bus.opcode == OPC_JNZ) begin
                    state_d = bus.zflag ? ST_FETCH_A : ST_JUMP;
                end else if (bus.opcode == OPC_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_JUMP: begin
                ctrl    = pc_ctrl(PC_WE);
                state_d = ST_FETCH_A;
            end
            ST_EXEC: begin
                alu_en  = 1'b1;
                state_d = ST_FETCH_A;
            end
            ST_HALTED: begin
                halted  = 1'b1;
                state_d = bus.start ? ST_FETCH_A : ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction count follows PC reset; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_PCRST) begin
            cnt_q <= '0;
        end else if (state_q == ST_DECODE) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign bus.ctrlsig   = ctrl;
    assign bus.ar_ld     = ar_ld;
    assign bus.mem_rd    = mem_rd;
    assign bus.ir_ld     = ir_ld;
    assign bus.alu_en    = alu_en;
    assign bus.halted    = halted;
    assign bus.instr_cnt = cnt_q;
    assign bus.state_o   = state_q;

    a_ctrl_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(ctrl));
    a_alu_excl:     assert property (@(posedge clk) disable iff (reset) !(alu_en && (ctrl != '0)));

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Bench for fetch_ctrl_unit: directed traces, a decode-timing vector table and a randomized
// instruction-level reference model; a MEM_WAIT=1 / narrow-counter instance covers dwell and wrap.
module tb_fetch_ctrl_unit;
    import fetch_ctrl_unit_pkg::*;

    localparam int MW_A   = 2;
    localparam int MW_B   = 1;
    localparam int CNTW_B = 6;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_unit_if #(.OPW(4), .CNTW(16))     bus_a ();
    fetch_ctrl_unit_if #(.OPW(4), .CNTW(CNTW_B)) bus_b ();

    fetch_ctrl_unit #(.OPW(4), .MEM_WAIT(MW_A), .CNTW(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    fetch_ctrl_unit #(.OPW(4), .MEM_WAIT(MW_B), .CNTW(CNTW_B)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output pattern each state must show: {ctrlsig, ar_ld, mem_rd, ir_ld, alu_en, halted}.
    typedef struct packed {
        logic [2:0] ctrl;
        logic       ar;
        logic       rd;
        logic       ir;
        logic       alu;
        logic       hlt;
    } outs_t;

    function automatic outs_t spec_outs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            ST_PCRST:   o.ctrl = 3'b100;
            ST_FETCH_A: o.ar   = 1'b1;
            ST_FETCH_M: o.rd   = 1'b1;
            ST_FETCH_I: begin o.ir = 1'b1; o.ctrl = 3'b010; end
            ST_JUMP:    o.ctrl = 3'b001;
            ST_EXEC:    o.alu  = 1'b1;
            ST_HALTED:  o.hlt  = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

    // Reference model: instruction-level plan of upcoming states.
    state_t      m_cur;
    state_t      m_q[$];
    logic [15:0] m_cnt;

    function automatic void plan_fetch();
        m_q.push_back(ST_FETCH_A);
        for (int i = 0; i < MW_A; i++) m_q.push_back(ST_FETCH_M);
        m_q.push_back(ST_FETCH_I);
        m_q.push_back(ST_DECODE);
    endfunction

    function automatic void model_step(input logic st, input logic [3:0] op, input logic z);
        if (m_cur == ST_PCRST)  m_cnt = 16'd0;
        if (m_cur == ST_DECODE) m_cnt = m_cnt + 16'd1;
        if (m_q.size() == 0) begin
            if (m_cur == ST_IDLE && st) begin
                m_q.push_back(ST_PCRST);
                plan_fetch();
            end else if (m_cur == ST_HALTED && st) begin
                plan_fetch();
            end else if (m_cur == ST_DECODE) begin
                if (op == OP_HALT) begin
                    m_q.push_back(ST_HALTED);
                end else if (op == OP_NOP || (op == OP_JZ && !z) || (op == OP_JNZ && z)) begin
                    plan_fetch();
                end else if (op == OP_JMP || op == OP_JZ || op == OP_JNZ) begin
                    m_q.push_back(ST_JUMP);
                    plan_fetch();
                end else begin
                    m_q.push_back(ST_EXEC);
                    plan_fetch();
                end
            end
        end
        if (m_q.size() != 0) m_cur = m_q.pop_front();
    endfunction

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         cycles;
        int         jumps;
        int         alus;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc, jmp, alu, seen, halt_cycles;
        logic [15:0] cnt0;
        outs_t got;
        state_t trace[8];

        vecs[0] = '{4'h0, 1'b0, 5, 0, 0};
        vecs[1] = '{4'h5, 1'b0, 6, 0, 1};
        vecs[2] = '{4'h1, 1'b1, 6, 1, 0};
        vecs[3] = '{4'h2, 1'b1, 6, 1, 0};
        vecs[4] = '{4'h2, 1'b0, 5, 0, 0};
        vecs[5] = '{4'h3, 1'b0, 6, 1, 0};
        vecs[6] = '{4'h3, 1'b1, 5, 0, 0};
        vecs[7] = '{4'hE, 1'b1, 6, 0, 1};
        trace   = '{ST_PCRST, ST_FETCH_A, ST_FETCH_M, ST_FETCH_M, ST_FETCH_I, ST_DECODE, ST_EXEC, ST_FETCH_A};

        bus_a.start = 1'b0; bus_a.opcode = 4'h0; bus_a.zflag = 1'b0;
        bus_b.start = 1'b0; bus_b.opcode = 4'h0; bus_b.zflag = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_state", bus_a.state_o, ST_IDLE);
        got = {bus_a.ctrlsig, bus_a.ar_ld, bus_a.mem_rd, bus_a.ir_ld, bus_a.alu_en, bus_a.halted};
        check("rst_outs", got, 8'h00);
        check("rst_cnt", bus_a.instr_cnt, 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("first_edge_idle", bus_a.state_o, ST_IDLE);

        // Start with an ALU op: full trace
        bus_a.start = 1'b1; bus_a.opcode = 4'h5;
        alu = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            check($sformatf("trace_%0d", i), bus_a.state_o, trace[i]);
            if (trace[i] == ST_PCRST)   check("pcrst_ctrl", bus_a.ctrlsig, 3'b100);
            if (trace[i] == ST_FETCH_I) check("fetchi_ctrl", bus_a.ctrlsig, 3'b010);
            if (bus_a.alu_en) alu++;
        end
        check("trace_alu_cycles", alu, 1);
        check("trace_cnt", bus_a.instr_cnt, 1);

        // Decode timing table, FETCH_A to next FETCH_A
        for (int v = 0; v < 8; v++) begin
            bus_a.opcode = vecs[v].op;
            bus_a.zflag  = vecs[v].z;
            cnt0 = bus_a.instr_cnt;
            cyc = 0; jmp = 0; alu = 0; seen = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (bus_a.ctrlsig == 3'b001) jmp++;
                if (bus_a.ctrlsig == 3'b100) seen++;
                if (bus_a.alu_en) alu++;
            end while (bus_a.state_o != ST_FETCH_A && cyc < 20);
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].cycles);
            check($sformatf("vec%0d_jump", v), jmp, vecs[v].jumps);
            check($sformatf("vec%0d_alu", v), alu, vecs[v].alus);
            check($sformatf("vec%0d_no_pcrst", v), seen, 0);
            check($sformatf("vec%0d_cnt", v), bus_a.instr_cnt, 32'(cnt0) + 1);
        end

        // HALT, hold, resume without PC reset
        bus_a.opcode = OP_HALT;
        cnt0 = bus_a.instr_cnt;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus_a.state_o != ST_HALTED && cyc < 12);
        check("halt_reached", bus_a.state_o, ST_HALTED);
        bus_a.opcode = OP_NOP;
        halt_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.halted && bus_a.state_o == ST_HALTED) halt_cycles++;
        end
        check("halt_hold", halt_cycles, 20);
        check("halt_cnt", bus_a.instr_cnt, 32'(cnt0) + 1);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check("resume_state", bus_a.state_o, ST_FETCH_A);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_a.ctrlsig == 3'b100) seen++;
            @(negedge clk);
        end
        check("resume_no_pcrst", seen, 0);
        check("resume_cnt", bus_a.instr_cnt, 32'(cnt0) + 2);

        // start ignored in FETCH_M, then reset in 2nd FETCH_M
        cyc = 0;
        while (bus_a.state_o != ST_FETCH_M && cyc < 12) begin @(negedge clk); cyc++; end
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        check("start_ignored_m", bus_a.state_o, ST_FETCH_M);
        #2 rst_a = 1'b1;
        #1;
        check("abort_state", bus_a.state_o, ST_IDLE);
        check("abort_mem_rd", bus_a.mem_rd, 1'b0);
        check("abort_cnt", bus_a.instr_cnt, 0);
        check("abort_ctrl", bus_a.ctrlsig, 3'b000);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("post_abort_idle", bus_a.state_o, ST_IDLE);

        // MEM_WAIT=1 instance: dwell, NOP period, counter wrap
        rst_b = 1'b0;
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cyc = 0;
        while (bus_b.state_o != ST_FETCH_A && cyc < 8) begin @(negedge clk); cyc++; end
        cyc = 0; seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus_b.state_o == ST_FETCH_M) seen++;
        end while (bus_b.state_o != ST_FETCH_A && cyc < 20);
        check("mw1_period", cyc, 4);
        check("mw1_fetch_m", seen, 1);
        cyc = 0;
        while (bus_b.instr_cnt != 6'h3F && cyc < 400) begin @(negedge clk); cyc++; end
        check("mw1_cnt_max", bus_b.instr_cnt, 6'h3F);
        cyc = 0;
        while (bus_b.instr_cnt == 6'h3F && cyc < 10) begin @(negedge clk); cyc++; end
        check("mw1_cnt_wrap", bus_b.instr_cnt, 6'h00);

        // Randomized run against the instruction-level model
        rst_a = 1'b1;
        m_cur = ST_IDLE; m_q.delete(); m_cnt = 16'd0;
        for (int c = 0; c < 4000; c++) begin
            logic st, z;
            logic [3:0] op;
            @(negedge clk);
            got = {bus_a.ctrlsig, bus_a.ar_ld, bus_a.mem_rd, bus_a.ir_ld, bus_a.alu_en, bus_a.halted};
            check("rnd_state", bus_a.state_o, m_cur);
            check("rnd_outs", got, spec_outs(m_cur));
            check("rnd_cnt", bus_a.instr_cnt, m_cnt);
            st = ($urandom_range(0, 7) == 0);
            op = 4'($urandom_range(0, 15));
            z  = 1'($urandom_range(0, 1));
            bus_a.start = st; bus_a.opcode = op; bus_a.zflag = z;
            if (!rst_a && $urandom_range(0, 399) == 0) begin
                rst_a = 1'b1;
                m_cur = ST_IDLE; m_q.delete(); m_cnt = 16'd0;
            end else begin
                rst_a = 1'b0;
                model_step(st, op, z);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
